// File: rtl/vga_frame_timing_if.sv
// rtl/vga_frame_timing_if.sv - display timing bundle between the timing generator and pattern consumers
// Purpose: groups the pixel-timing outputs and the frame-advance controls into one bundle.
// Signals: pause, step      - frame-advance controls (consumer -> timing)
//          x, y             - pixel coordinates
//          active           - visible-area qualifier
//          hsync, vsync     - active-low syncs
//          next_frame       - one-cycle frame-advance pulse
//          frame_count      - number of next_frame pulses issued (wraps)
// Modports: master = timing generator, slave = consumer / controller.
interface vga_frame_timing_if;
   logic       pause;
   logic       step;
   logic [9:0] x;
   logic [9:0] y;
   logic       active;
   logic       hsync;
   logic       vsync;
   logic       next_frame;
   logic [7:0] frame_count;

   modport master (
      input  pause, step,
      output x, y, active, hsync, vsync, next_frame, frame_count
   );

   modport slave (
      output pause, step,
      input  x, y, active, hsync, vsync, next_frame, frame_count
   );
endinterface

// File: rtl/vga_frame_timing.sv
// rtl/vga_frame_timing.sv - pixel/line counters, sync decode and divided frame-advance pulse
// Purpose: generates x/y pixel coordinates, active/hsync/vsync decodes and a one-cycle
//          next_frame pulse every FRAME_DIV unpaused frames, issued in the x=0,y=0 cycle.
// Ports:   clk      - pixel clock
//          rst_n    - asynchronous active-low reset
//          bus      - vga_frame_timing_if.master (pause, step in; x, y, active, hsync,
//                     vsync, next_frame, frame_count out)
// Option:  FRAME_STEP_EN - when defined, a synchronised rising edge of step while paused
//          forces one next_frame at the next frame end without touching the divider.
module vga_frame_timing #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int FRAME_DIV = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   vga_frame_timing_if.master bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);

   logic [9:0] x_q;
   logic [9:0] y_q;
   logic [3:0] div_cnt;
   logic [7:0] frame_cnt;
   logic       next_q;
   logic       frame_end;
   logic       div_fire;
   logic       step_fire;
   logic       fire;

   assign frame_end = (x_q == X_LAST) && (y_q == Y_LAST);
   assign div_fire  = frame_end && !bus.pause && (div_cnt == DIV_LAST);
   assign fire      = div_fire || step_fire;

`ifdef FRAME_STEP_EN
   logic step_meta;
   logic step_sync;
   logic step_prev;
   logic step_pending;

   // A pending step only survives while paused; unpausing hands control back to the divider.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_meta    <= 1'b0;
         step_sync    <= 1'b0;
         step_prev    <= 1'b0;
         step_pending <= 1'b0;
      end else begin
         step_meta <= bus.step;
         step_sync <= step_meta;
         step_prev <= step_sync;
         if (!bus.pause)
            step_pending <= 1'b0;
         else if (frame_end && step_pending)
            step_pending <= 1'b0;
         else if (step_sync && !step_prev)
            step_pending <= 1'b1;
      end
   end

   assign step_fire = frame_end && bus.pause && step_pending;
`else
   logic unused_step;
   assign unused_step = bus.step;
   assign step_fire   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q       <= '0;
         y_q       <= '0;
         div_cnt   <= '0;
         frame_cnt <= '0;
         next_q    <= 1'b0;
      end else begin
         if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= (y_q == Y_LAST) ? '0 : y_q + 10'd1;
         end else begin
            x_q <= x_q + 10'd1;
         end
         // Divider only moves on unpaused frame ends; a step pulse leaves it untouched.
         if (frame_end && !bus.pause)
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 4'd1;
         next_q <= fire;
         if (fire)
            frame_cnt <= frame_cnt + 8'd1;
      end
   end

   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.active      = (x_q < X_ACT) && (y_q < Y_ACT);
   assign bus.hsync       = !((x_q >= HS_START) && (x_q < HS_END));
   assign bus.vsync       = !((y_q >= VS_START) && (y_q < VS_END));
   assign bus.next_frame  = next_q;
   assign bus.frame_count = frame_cnt;
endmodule
